// File: rtl/cp_l2mem_arbiter_if.sv
// cp_l2mem_arbiter_if: client-side bus of the shared L2 data memory.
//
// Signals (flattened per-port vectors, port i at [i*W +: W]):
//   trq          client -> arb  per-port transfer request, held for the whole ownership
//   addr         client -> arb  per-port word address
//   in           client -> arb  per-port write data
//   we           client -> arb  per-port write enable
//   tack         arb -> client  per-port grant acknowledge (one-hot or zero)
//   dmem_l2_out  arb -> client  registered read data, shared by all ports
//   rd_valid     arb -> client  one-hot strobe qualifying dmem_l2_out
//   owner        arb -> client  index of the current owner (meaningful while busy)
//   busy         arb -> client  an ownership is active
// Modports: master (client cluster side), slave (arbiter side).
interface cp_l2mem_arbiter_if #(
    parameter int unsigned CP_D_WIDTH      = 72,
    parameter int unsigned DMEM_ADDR_WIDTH = 10,
    parameter int unsigned NUM_CP          = 12
);
    localparam int unsigned OwnerW = $clog2(NUM_CP);

    logic [NUM_CP-1:0]                 trq;
    logic [NUM_CP-1:0]                 tack;
    logic [NUM_CP*DMEM_ADDR_WIDTH-1:0] addr;
    logic [NUM_CP*CP_D_WIDTH-1:0]      in;
    logic [NUM_CP-1:0]                 we;
    logic [CP_D_WIDTH-1:0]             dmem_l2_out;
    logic [NUM_CP-1:0]                 rd_valid;
    logic [OwnerW-1:0]                 owner;
    logic                              busy;

    modport master (
        output trq, addr, in, we,
        input  tack, dmem_l2_out, rd_valid, owner, busy
    );

    modport slave (
        input  trq, addr, in, we,
        output tack, dmem_l2_out, rd_valid, owner, busy
    );
endinterface

// File: rtl/cp_l2mem_arbiter.sv
// cp_l2mem_arbiter: shared single-port L2 data memory for NUM_CP co-processor clients.
// Round-robin arbitration over a trq/tack request-hold handshake; the owner accesses the
// RAM in every cycle its tack is high (write if we, else read with one-cycle latency).
//
// Ports:
//   clock   in   single clock, rising edge
//   nreset  in   asynchronous active-low reset
//   bus     slave modport of cp_l2mem_arbiter_if (trq/addr/in/we in; tack/dmem_l2_out/
//           rd_valid/owner/busy out)
//
// Optional feature: define CP_L2MEM_HOLD_LIMIT_EN to bound an ownership to MAX_HOLD
// consecutive granted cycles while other ports are waiting.
module cp_l2mem_arbiter #(
    parameter int unsigned CP_D_WIDTH      = 72,
    parameter int unsigned DMEM_ADDR_WIDTH = 10,
    parameter int unsigned NUM_CP          = 12,
    parameter int unsigned MAX_HOLD        = 64
) (
    input logic               clock,
    input logic               nreset,
    cp_l2mem_arbiter_if.slave bus
);
    localparam int unsigned OwnerW = $clog2(NUM_CP);
    localparam int unsigned Depth  = 2 ** DMEM_ADDR_WIDTH;

    if (NUM_CP < 2 || NUM_CP > 32 || MAX_HOLD < 2) begin : g_param_check
        $error("cp_l2mem_arbiter: NUM_CP must be 2..32 and MAX_HOLD >= 2");
    end

    typedef enum logic {StIdle, StGrant} state_e;

    state_e              state_q, state_d;
    logic [OwnerW-1:0]   owner_q, owner_d;
    logic [OwnerW-1:0]   last_q, last_d;
    logic [NUM_CP-1:0]   others;
    logic                hold_expired;
    logic                acc, acc_we;
    logic [DMEM_ADDR_WIDTH-1:0] acc_addr;
    logic [CP_D_WIDTH-1:0]      acc_wdata;
    logic [NUM_CP-1:0]          rd_valid_q;
    logic [CP_D_WIDTH-1:0]      dout_q;
    logic [CP_D_WIDTH-1:0]      mem [Depth];

    // First set bit of req searching upward from (from+1), wrapping; from itself is last.
    function automatic logic [OwnerW-1:0] rr_pick(input logic [NUM_CP-1:0] req,
                                                  input logic [OwnerW-1:0] from);
        logic [OwnerW-1:0] pick;
        logic              found;
        int unsigned       idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_CP; k++) begin
            idx = (32'(from) + k) % NUM_CP;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = OwnerW'(idx);
            end
        end
        return pick;
    endfunction

    // State register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= OwnerW'(NUM_CP - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        // Excluding the owner makes a drop-and-reraise wait for everyone else in rotation.
        others  = bus.trq & ~(NUM_CP'(1) << owner_q);
        unique case (state_q)
            StIdle: begin
                if (|bus.trq) begin
                    state_d = StGrant;
                    owner_d = rr_pick(bus.trq, last_q);
                    last_d  = owner_d;
                end
            end
            StGrant: begin
                if (!bus.trq[owner_q] || hold_expired) begin
                    if (|others) begin
                        owner_d = rr_pick(others, owner_q);
                        last_d  = owner_d;
                    end else if (!bus.trq[owner_q]) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.tack = '0;
        if (state_q == StGrant) begin
            bus.tack[owner_q] = bus.trq[owner_q];
        end
        bus.busy  = (state_q == StGrant);
        bus.owner = owner_q;
    end

`ifdef CP_L2MEM_HOLD_LIMIT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD);

    logic [HoldW-1:0] hold_q, hold_d;

    assign hold_expired = (hold_q == HoldW'(MAX_HOLD - 1));

    // Counts cycles of the current ownership; saturates when nobody else is waiting.
    always_comb begin
        hold_d = '0;
        if (state_q == StGrant && state_d == StGrant && owner_d == owner_q) begin
            hold_d = hold_expired ? hold_q : hold_q + HoldW'(1);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // RAM access of the owner, only in cycles its tack is high
    assign acc       = (state_q == StGrant) && bus.trq[owner_q];
    assign acc_we    = bus.we[owner_q];
    assign acc_addr  = bus.addr[owner_q * DMEM_ADDR_WIDTH +: DMEM_ADDR_WIDTH];
    assign acc_wdata = bus.in[owner_q * CP_D_WIDTH +: CP_D_WIDTH];

    always_ff @(posedge clock) begin
        if (acc && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rd_valid_q <= '0;
            dout_q     <= '0;
        end else begin
            rd_valid_q <= '0;
            if (acc && !acc_we) begin
                rd_valid_q[owner_q] <= 1'b1;
                dout_q              <= mem[acc_addr];
            end
        end
    end

    assign bus.rd_valid    = rd_valid_q;
    assign bus.dmem_l2_out = dout_q;
endmodule

// File: tb/tb_cp_l2mem_arbiter.sv
// tb_cp_l2mem_arbiter: directed self-checking bench for cp_l2mem_arbiter.
// Inputs change 1 time unit after each rising edge; outputs are sampled mid-cycle.
module tb_cp_l2mem_arbiter;
    localparam int unsigned DW = 72;
    localparam int unsigned AW = 10;
    localparam int unsigned N  = 12;
    localparam int unsigned MH = 4;

    logic clock  = 1'b0;
    logic nreset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    cp_l2mem_arbiter_if #(.CP_D_WIDTH(DW), .DMEM_ADDR_WIDTH(AW), .NUM_CP(N)) bus ();

    cp_l2mem_arbiter #(
        .CP_D_WIDTH      (DW),
        .DMEM_ADDR_WIDTH (AW),
        .NUM_CP          (N),
        .MAX_HOLD        (MH)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic w);
        bus.addr[p*AW +: AW] = a;
        bus.in[p*DW +: DW]   = d;
        bus.we[p]            = w;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        #1;
        @(posedge clock);
        #1;
        nreset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_tack;
        bus.trq  = '0;
        bus.we   = '0;
        bus.addr = '0;
        bus.in   = '0;

        // Reset values
        #1 nreset = 1'b0;
        #2;
        check("rst_tack", bus.tack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_dout", bus.dmem_l2_out, 0);
        check("rst_owner", bus.owner, 0);
        @(posedge clock);
        next_cycle();
        nreset = 1'b1;

        // Write 0xA5 to addr 5 three times, then read it back
        bus.trq = 12'h001;
        set_port(0, 10'd5, 72'hA5, 1'b1);
        #3 check("t1_latency", bus.tack, 0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            #3 check("t1_wr_tack", bus.tack, 12'h001);
            next_cycle();
        end
        bus.we[0] = 1'b0;
        #3 check("t1_rd_tack", bus.tack, 12'h001);
        check("t1_busy", bus.busy, 1);
        next_cycle();
        bus.trq = '0;
        #3 check("t1_rd_valid", bus.rd_valid, 12'h001);
        check("t1_rd_data", bus.dmem_l2_out, 72'hA5);
        next_cycle();
        #3 check("t1_rv_pulse", bus.rd_valid, 0);
        check("t1_data_hold", bus.dmem_l2_out, 72'hA5);
        check("t1_idle", bus.busy, 0);
        next_cycle();

        // All ports request from reset; each keeps tack two cycles then drops trq
        do_reset();
        bus.trq = 12'hFFF;
        #3 check("t2_latency", bus.tack, 0);
        next_cycle();
        for (int p = 0; p < 12; p++) begin
            for (int r = 0; r < 2; r++) begin
                #3 check("t2_grant", bus.tack, 1 << p);
                check("t2_owner", bus.owner, p);
                next_cycle();
            end
            bus.trq[p] = 1'b0;
            #3 check("t2_drop_tack", bus.tack, 0);
            check("t2_drop_busy", bus.busy, 1);
            next_cycle();
        end
        #3 check("t2_idle", bus.busy, 0);
        next_cycle();

        // Port 3 owns, 1 and 7 request, 3 releases -> 7 then 1
        bus.trq = 12'h008;
        #3 check("t3_latency", bus.tack, 0);
        next_cycle();
        bus.trq = 12'h08A;
        #3 check("t3_own3", bus.tack, 12'h008);
        next_cycle();
        bus.trq = 12'h082;
        #3 check("t3_rel3", bus.tack, 0);
        check("t3_rel3_owner", bus.owner, 3);
        next_cycle();
        #3 check("t3_own7", bus.tack, 12'h080);
        check("t3_owner7", bus.owner, 7);
        next_cycle();
        bus.trq = 12'h002;
        #3 check("t3_rel7", bus.tack, 0);
        next_cycle();
        #3 check("t3_own1", bus.tack, 12'h002);
        next_cycle();
        bus.trq = '0;
        next_cycle();

        // Port 5 preloads addr k with k, then burst-reads 0..7
        bus.trq = 12'h020;
        set_port(5, 10'd0, 72'd0, 1'b1);
        #3 check("t4_latency", bus.tack, 0);
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            set_port(5, AW'(k), DW'(k), 1'b1);
            #3 check("t4_wr_tack", bus.tack, 12'h020);
            next_cycle();
        end
        for (int k = 0; k < 8; k++) begin
            set_port(5, AW'(k), 72'd0, 1'b0);
            #3;
            if (k > 0) begin
                check("t4_rd_valid", bus.rd_valid, 12'h020);
                check("t4_rd_data", bus.dmem_l2_out, k - 1);
            end else begin
                check("t4_no_rv_after_wr", bus.rd_valid, 0);
            end
            next_cycle();
        end
        bus.trq = '0;
        #3 check("t4_rd_valid_last", bus.rd_valid, 12'h020);
        check("t4_rd_data_last", bus.dmem_l2_out, 7);
        next_cycle();
        #3 check("t4_rv_end", bus.rd_valid, 0);
        next_cycle();

        // Reset in the middle of a read burst by port 2
        bus.trq = 12'h004;
        set_port(2, 10'd3, 72'd0, 1'b0);
        next_cycle();
        #3 check("t5_tack", bus.tack, 12'h004);
        next_cycle();
        set_port(2, 10'd4, 72'd0, 1'b0);
        #3 check("t5_pre_data", bus.dmem_l2_out, 3);
        nreset = 1'b0;
        #1;
        check("t5_rst_tack", bus.tack, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_rv", bus.rd_valid, 0);
        check("t5_rst_dout", bus.dmem_l2_out, 0);
        next_cycle();
        nreset  = 1'b1;
        bus.trq = 12'h205;
        #3 check("t5_no_inflight_rv", bus.rd_valid, 0);
        check("t5_latency", bus.tack, 0);
        next_cycle();
        #3 check("t5_port0_first", bus.tack, 12'h001);
        check("t5_owner0", bus.owner, 0);
        next_cycle();
        bus.trq = '0;
        next_cycle();

        // Ports 0 and 2 held high: hold limit alternates them, otherwise port 0 keeps it
        do_reset();
        bus.trq = 12'h005;
        #3 check("t6_latency", bus.tack, 0);
        next_cycle();
        for (int k = 0; k < 12; k++) begin
`ifdef CP_L2MEM_HOLD_LIMIT_EN
            exp_tack = ((k / 4) % 2 == 1) ? 12'h004 : 12'h001;
`else
            exp_tack = 12'h001;
`endif
            #3 check("t6_hold", bus.tack, exp_tack);
            next_cycle();
        end
        bus.trq = '0;
        next_cycle();
        #3 check("t6_idle", bus.busy, 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cp_l2mem_arbiter.md
# cp_l2mem_arbiter

Parametrised shared L2 data memory for the co-processor array: NUM_CP clients contend for a single-port synchronous RAM through a trq/tack request-hold handshake. Compared with the fixed 12-port sequential-scan memory, it adds round-robin arbitration, same-cycle-free back-to-back handover, per-port read-valid strobes and an optional hold-time limit. It sits between the CP cluster and the L2 storage, one instance per L2 bank.

## Interface
- CP_D_WIDTH, 72, data word width.
- DMEM_ADDR_WIDTH, 10, word address width; depth = 2^DMEM_ADDR_WIDTH.
- NUM_CP, 12, number of client ports, legal range 2..32.
- MAX_HOLD, 64, maximum consecutive granted cycles per ownership when the hold limit is compiled in, legal range >= 2.

- clock  in  1  single clock; all state on its rising edge.
- nreset  in  1  reset, asynchronous assert, active-low.
- trq  in  NUM_CP  per-port transfer request, held high for the whole ownership.
- tack  out  NUM_CP  per-port grant acknowledge (one-hot or zero).
- addr  in  NUM_CP*DMEM_ADDR_WIDTH  flattened addresses, port i at [i*DMEM_ADDR_WIDTH +: DMEM_ADDR_WIDTH].
- in  in  NUM_CP*CP_D_WIDTH  flattened write data, port i at [i*CP_D_WIDTH +: CP_D_WIDTH].
- we  in  NUM_CP  per-port write enable.
- dmem_l2_out  out  CP_D_WIDTH  registered read data, shared by all ports.
- rd_valid  out  NUM_CP  one-hot strobe: dmem_l2_out carries the read issued by port i in the previous cycle.
- owner  out  $clog2(NUM_CP)  index of current owner; meaningful only while busy.
- busy  out  1  high in GRANT state.

## Operation
- States: IDLE, GRANT. Registers: state, owner, last (last granted port), hold counter.
- Arbitration: search trq starting at (last+1) mod NUM_CP, wrapping; first set bit wins. Index NUM_CP-1 wraps to 0.
- IDLE: any trq set -> GRANT with owner = winner, last = winner; else stay.
- GRANT: trq[owner] high -> stay (subject to hold limit); trq[owner] low -> if any other trq set, GRANT with next winner (searched from owner+1); else IDLE.
- tack[i] = busy && owner==i && trq[i] (combinational); all others 0.
- Memory access occurs only in cycles where tack[owner] is 1: we[owner]=1 writes in[owner] to addr[owner]; we[owner]=0 reads addr[owner].
- Read-during-write same address cannot occur (single port); RAM is read-first for the written word irrelevant.
- dmem_l2_out updates only on a read; otherwise holds its last value.
- RAM contents are not reset.

## Timing
- Reset values: state IDLE, last = NUM_CP-1 (port 0 has first priority), owner 0, busy 0, tack 0, rd_valid 0, dmem_l2_out 0, hold counter 0.
- Grant latency: trq[i] sampled high at edge t in IDLE -> tack[i] high in cycle t+1.
- Handover: owner drops trq in cycle t with port j requesting -> tack[j] high in cycle t+1; zero dead cycles.
- Read latency: read accepted in cycle t -> dmem_l2_out valid and rd_valid[owner] high in cycle t+1 for exactly one cycle per read; back-to-back reads stream one word per cycle.
- Writes commit at the end of the tack cycle.
- Owner dropping and re-raising trq immediately is served after all other pending requesters in rotation order.
- Reset mid-operation: tack, busy, rd_valid drop immediately on nreset low; an in-flight read produces no rd_valid.

## Configuration
- CP_L2MEM_HOLD_LIMIT_EN defined: hold counter increments each GRANT cycle, clears on ownership change. When it reaches MAX_HOLD-1 and any other trq is set, the next cycle grants the next round-robin winner; the preempted port sees tack drop, keeps trq high and is re-granted in its turn. With no other requester, the owner keeps the grant and the counter saturates.
- Not defined: no counter; owner holds indefinitely while trq is high.

## Test plan
- Reset, then trq=12'h001, we=1, addr 5, in 72'hA5 for 3 cycles, then read addr 5 -> tack[0] one cycle after trq, dmem_l2_out=72'hA5 with rd_valid[0] one cycle after the read.
- trq=12'hFFF from reset, each port releases after 2 cycles -> grant order 0,1,...,11, each handover with no gap.
- Port 3 owns; ports 1 and 7 request; port 3 releases -> order 7 then 1 (rotation from 4).
- Burst read of addresses 0..7 preloaded with value=addr -> dmem_l2_out 0..7 on consecutive cycles, rd_valid continuous.
- nreset low mid-burst -> tack, rd_valid, dmem_l2_out zero immediately; after release port 0 wins first.
- With CP_L2MEM_HOLD_LIMIT_EN, MAX_HOLD=4, ports 0 and 2 held high -> tack alternates 4 cycles port 0, 4 cycles port 2.
